bt_cmd_rx: RTL and testbench

Bluetooth command receiver for the car-set control path. Deserialises 8N1 UART bytes from the Bluetooth module's TX line using 16x oversampling. Presents every received byte as a one-cycle strobe. Filters the four control characters ('1'..'4') into a held command byte on `cmd`. `cmd` feeds the volume/song adjust stage directly, which reads it as a level and applies its own repeat delay.

---
 rtl/bt_pkg.sv | 12 +
 rtl/bt_baud_tick.sv | 16 +
 rtl/bt_cmd_rx.sv | 83 ++++++++
 tb/tb_bt_cmd_rx.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bt_pkg.sv
// bt_pkg: shared state encoding and control-character constants for the Bluetooth command path
package bt_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  localparam logic [7:0] CMD_NONE      = 8'h00;
  localparam logic [7:0] CMD_VOL_UP    = 8'h31;
  localparam logic [7:0] CMD_VOL_DN    = 8'h32;
  localparam logic [7:0] CMD_SONG_PREV = 8'h33;
  localparam logic [7:0] CMD_SONG_NEXT = 8'h34;
  function automatic logic is_cmd(input logic [7:0] b);
    return b >= CMD_VOL_UP && b <= CMD_SONG_NEXT;
  endfunction
endpackage

// File: rtl/bt_baud_tick.sv
// bt_baud_tick: 16x oversample tick generator, held at zero while clr is high
module bt_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = !clr && cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/bt_cmd_rx.sv
// bt_cmd_rx: 8N1 UART receiver with 16x oversampling that holds recognised
// control characters on cmd for CMD_HOLD cycles.
module bt_cmd_rx
  import bt_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int CMD_HOLD = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic [7:0] cmd,
  output logic       frame_err
);
  localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int HW  = $clog2(CMD_HOLD + 1);
  state_t state, nxt;
  logic rx_m, rxs, rxs_q, tick, maj, s7, s9, s15, ok, bad;
  logic [3:0] scnt;
  logic [2:0] bcnt;
  logic [1:0] smp;
  logic [7:0] sh;
  logic [HW-1:0] hold;
  bt_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst_n(rst_n), .clr(state == IDLE), .tick(tick));
  assign s7  = tick && scnt == 4'd7;
  assign s9  = tick && scnt == 4'd9;
  assign s15 = tick && scnt == 4'd15;
  // ticks 7 and 8 are latched in smp; the tick-9 sample is the live rxs
  assign maj = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign ok  = state == STOP && s9 && maj;
  assign bad = state == STOP && s9 && !maj;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = (rxs_q && !rxs) ? START : IDLE;
      START:     nxt = s7 ? (rxs ? IDLE : DATA) : START;
      DATA:      nxt = (s15 && bcnt == 3'd7) ? STOP : DATA;
      STOP:      nxt = s9 ? (maj ? IDLE : WAIT_IDLE) : STOP;
      WAIT_IDLE: nxt = rxs ? IDLE : WAIT_IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_m       <= 1'b1;
      rxs        <= 1'b1;
      rxs_q      <= 1'b1;
      state      <= IDLE;
      scnt       <= '0;
      bcnt       <= '0;
      smp        <= '0;
      sh         <= '0;
      data       <= CMD_NONE;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      cmd        <= CMD_NONE;
      hold       <= '0;
    end else begin
      rx_m       <= rx;
      rxs        <= rx_m;
      rxs_q      <= rxs;
      state      <= nxt;
      scnt       <= (state == IDLE || (state == START && s7)) ? '0 : scnt + 4'(tick);
      bcnt       <= state == IDLE ? '0 : bcnt + 3'(state == DATA && s15);
      if (tick && scnt == 4'd7) smp[0] <= rxs;
      if (tick && scnt == 4'd8) smp[1] <= rxs;
      if (state == DATA && s9) sh <= {maj, sh[7:1]};
      data_valid <= ok;
      frame_err  <= bad;
      if (ok) data <= sh;
      // a fresh command outranks expiry of the previous one
      if (ok && is_cmd(sh)) begin
        cmd  <= sh;
        hold <= HW'(CMD_HOLD);
      end else if (hold != '0) begin
        hold <= hold - 1'b1;
        if (hold == HW'(1)) cmd <= CMD_NONE;
      end
    end
endmodule

// File: tb/tb_bt_cmd_rx.sv
// tb_bt_cmd_rx: scoreboard bench; stimulus queues expected strobes, a monitor pops and checks them
module tb_bt_cmd_rx;
  import bt_pkg::*;
  localparam int BIT = 160;
  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
    logic [7:0] cmd;
    bit         load;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [7:0] data, cmd;
  logic data_valid, frame_err, dv_q = 1'b0, fe_q = 1'b0;
  int tests = 0, fails = 0, cyc = 0, load_cyc = 0;
  exp_t sb[$];
  logic [7:0] m_data = 8'h00;

  bt_cmd_rx #(.CLK_HZ(1_600_000), .BAUD(10_000), .CMD_HOLD(2000)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .data_valid(data_valid),
    .cmd(cmd), .frame_err(frame_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) chk("dv_width", {31'd0, dv_q}, 0);
      if (frame_err) chk("fe_width", {31'd0, fe_q}, 0);
      if (data_valid || frame_err) begin
        if (sb.size() == 0) chk("unexpected_strobe", {30'd0, data_valid, frame_err}, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("kind", {30'd0, data_valid, frame_err}, {30'd0, e.kind});
          chk("data", {24'd0, data}, {24'd0, e.data});
          chk("cmd", {24'd0, cmd}, {24'd0, e.cmd});
          if (e.load) load_cyc = cyc;
        end
      end
    end
    dv_q = data_valid;
    fe_q = frame_err;
  end

  task automatic expect_byte(input logic [7:0] b, input logic [7:0] c, input bit load);
    exp_t e;
    e.kind = 2'b10; e.data = b; e.cmd = c; e.load = load;
    m_data = b;
    sb.push_back(e);
  endtask

  task automatic expect_ferr(input logic [7:0] c);
    exp_t e;
    e.kind = 2'b01; e.data = m_data; e.cmd = c; e.load = 1'b0;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic hold_check(input string n);
    int k = 0;
    while (cmd !== 8'h00 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk(n, cyc - load_cyc, 2000);
  endtask

  task automatic reset_check(input string n);
    chk({n, "_data"}, {24'd0, data}, 0);
    chk({n, "_cmd"}, {24'd0, cmd}, 0);
    chk({n, "_strobes"}, {30'd0, data_valid, frame_err}, 0);
    chk({n, "_state"}, int'(dut.state), int'(IDLE));
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    reset_check("rst");
    repeat (5000) @(negedge clk);
    expect_byte(8'h31, 8'h31, 1);
    send(8'h31, 1'b1);
    hold_check("hold_31");
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_idle", int'(dut.state), int'(IDLE));
    expect_ferr(8'h00);
    send(8'h32, 1'b0);
    rx = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("ferr_cmd", {24'd0, cmd}, 0);
    expect_byte(8'h33, 8'h33, 1);
    send(8'h33, 1'b1);
    hold_check("hold_33");
    expect_byte(8'h34, 8'h34, 1);
    send(8'h34, 1'b1);
    expect_byte(8'h41, 8'h34, 0);
    send(8'h41, 1'b1);
    hold_check("hold_not_extended");
    expect_byte(8'h33, 8'h33, 1);
    send(8'h33, 1'b1);
    expect_byte(8'h34, 8'h34, 1);
    send(8'h34, 1'b1);
    hold_check("hold_b2b");
    expect_byte(8'h32, 8'h32, 1);
    send(8'h32, 1'b1);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_check("midrst");
    rst_n = 1'b1;
    repeat (3000) @(negedge clk);
    reset_check("post_rst");
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
